// File: rtl/manager_pkg.sv
// rtl/manager_pkg.sv - shared state encoding, frame constants and checksum helper for the manager FSMs
package manager_pkg;

    // State encoding shared with the receive-side FSM
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SEND = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_SEND = ST_SEND,
        S_WAIT = ST_WAIT,
        S_GAP  = ST_GAP,
        S_DONE = ST_DONE,
        S_ERR  = ST_ERR
    } tx_state_e;

    // Bytes in a frame without the checksum: cmd, addr, data
    localparam int FRAME_LEN_BASE = 3;

    // Command codes understood by the host protocol
    localparam logic [7:0] CMD_NOP    = 8'h00;
    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;

    // Frame checksum: XOR of the three payload bytes
    function automatic logic [7:0] frame_xor(input logic [7:0] cmd,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
        return cmd ^ addr ^ data;
    endfunction

endpackage

// File: rtl/manager_tx_timer.sv
// rtl/manager_tx_timer.sv - saturating cycle counter with clear, increment and match flag
module manager_tx_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] match_val,
    output logic             match
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority; increment stops at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match = (cnt_q == match_val);

endmodule

// File: rtl/manager_tx_fsm.sv
// rtl/manager_tx_fsm.sv - serialises {cmd, addr, data[, chk]} into the UART TX; MANAGER_TX_CHECKSUM_EN adds the checksum byte
module manager_tx_fsm
    import manager_pkg::*;
#(
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int CNT_W          = 26
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       tx_trg,
    input  logic [7:0] cmd_tx,
    input  logic [7:0] addr_tx,
    input  logic [7:0] data_tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [7:0] RS_DATAIN,
    output logic       RS_TRG,
    input  logic       RS_DONE
);

`ifdef MANAGER_TX_CHECKSUM_EN
    localparam int IDX_W    = 3;
    localparam int LAST_IDX = FRAME_LEN_BASE;
`else
    localparam int IDX_W    = 2;
    localparam int LAST_IDX = FRAME_LEN_BASE - 1;
`endif

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAST_IDX);
    // Match values are "cycles - 1" because the counter starts at 0 on state entry
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    tx_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
`ifdef MANAGER_TX_CHECKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif
    logic             tx_busy_q, tx_busy_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_err_q, tx_err_d;
    logic [7:0]       rs_datain_q, rs_datain_d;
    logic             rs_trg_q, rs_trg_d;
    logic [7:0]       byte_d;

    logic             tmr_clr;
    logic             tmr_inc;
    logic             tmr_match;
    logic [CNT_W-1:0] tmr_val;

    // Next state, byte index and capture registers
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef MANAGER_TX_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tx_trg) begin
                    cmd_d   = cmd_tx;
                    addr_d  = addr_tx;
                    data_d  = data_tx;
`ifdef MANAGER_TX_CHECKSUM_EN
                    chk_d   = frame_xor(cmd_tx, addr_tx, data_tx);
`endif
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                // A byte completing on the timeout cycle still counts as sent
                if (RS_DONE) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = (GAP_CYCLES == 0) ? S_SEND : S_GAP;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && tmr_match) begin
                    state_d = S_ERR;
                end
            end
            S_GAP: begin
                if (tmr_match) begin
                    state_d = S_SEND;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Byte selected by the next index, taken from the freshly captured values
    always_comb begin
        byte_d = cmd_d;
        case (idx_d)
            IDX_W'(1): byte_d = addr_d;
            IDX_W'(2): byte_d = data_d;
`ifdef MANAGER_TX_CHECKSUM_EN
            IDX_W'(3): byte_d = chk_d;
`endif
            default:   byte_d = cmd_d;
        endcase
    end

    // Timer is cleared on every state change and only runs in WAIT and GAP
    always_comb begin
        tmr_clr = (state_d != state_q);
        tmr_inc = (state_q == S_WAIT) || (state_q == S_GAP);
        tmr_val = (state_q == S_GAP) ? GAP_LAST : TO_LAST;
    end

    // Registered outputs decoded from the state being entered
    always_comb begin
        tx_busy_d   = (state_d == S_SEND) || (state_d == S_WAIT) || (state_d == S_GAP);
        tx_done_d   = (state_d == S_DONE);
        tx_err_d    = (state_d == S_ERR);
        rs_trg_d    = (state_d == S_SEND);
        rs_datain_d = (state_d == S_SEND) ? byte_d : rs_datain_q;
    end

    // State, capture and output registers
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cmd_q       <= 8'h00;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
`ifdef MANAGER_TX_CHECKSUM_EN
            chk_q       <= 8'h00;
`endif
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_err_q    <= 1'b0;
            rs_datain_q <= 8'h00;
            rs_trg_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
`ifdef MANAGER_TX_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
            tx_busy_q   <= tx_busy_d;
            tx_done_q   <= tx_done_d;
            tx_err_q    <= tx_err_d;
            rs_datain_q <= rs_datain_d;
            rs_trg_q    <= rs_trg_d;
        end
    end

    manager_tx_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk       (CLK_50MHZ),
        .rst       (RST),
        .clr       (tmr_clr),
        .inc       (tmr_inc),
        .match_val (tmr_val),
        .match     (tmr_match)
    );

    assign tx_busy   = tx_busy_q;
    assign tx_done   = tx_done_q;
    assign tx_err    = tx_err_q;
    assign RS_DATAIN = rs_datain_q;
    assign RS_TRG    = rs_trg_q;

endmodule

// File: tb/tb_manager_tx_fsm.sv
// tb/tb_manager_tx_fsm.sv - scoreboard bench for manager_tx_fsm with a UART TX response model
module tb_manager_tx_fsm;

    localparam int GAP = 4;
    localparam int TMO = 20;
`ifdef MANAGER_TX_CHECKSUM_EN
    localparam int FLEN = 4;
`else
    localparam int FLEN = 3;
`endif

    logic       clk = 1'b0;
    logic       RST;
    logic       tx_trg;
    logic [7:0] cmd_tx, addr_tx, data_tx;
    logic       tx_busy, tx_done, tx_err;
    logic [7:0] RS_DATAIN;
    logic       RS_TRG;
    logic       RS_DONE;

    manager_tx_fsm #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (26)
    ) dut (
        .CLK_50MHZ (clk),
        .RST       (RST),
        .tx_trg    (tx_trg),
        .cmd_tx    (cmd_tx),
        .addr_tx   (addr_tx),
        .data_tx   (data_tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_err    (tx_err),
        .RS_DATAIN (RS_DATAIN),
        .RS_TRG    (RS_TRG),
        .RS_DONE   (RS_DONE)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_bytes[$];
    int         exp_ev[$];
    int         dly[4];
    int         byte_no = 0;
    int         countdown = 0;
    int         trg_cnt = 0;
    int         ev_cnt = 0;
    int         ev_cyc = 0;
    int         done_cnt = 0;
    int         last_trg_cyc = 0;
    int         last_done_cyc = 0;
    logic [7:0] last_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                              input int n_push, input int ev);
        logic [7:0] f[4];
        f[0] = c;
        f[1] = a;
        f[2] = d;
        f[3] = c ^ a ^ d;
        for (int i = 0; i < n_push; i++) exp_bytes.push_back(f[i]);
        exp_ev.push_back(ev);
        byte_no = 0;
        @(negedge clk);
        cmd_tx  = c;
        addr_tx = a;
        data_tx = d;
        tx_trg  = 1'b1;
        @(negedge clk);
        tx_trg  = 1'b0;
    endtask

    task automatic wait_evt(input int snap);
        int k = 0;
        while (ev_cnt == snap && k < 2000) begin
            @(posedge clk);
            k++;
        end
        check("evt_seen", ev_cnt, snap + 1);
    endtask

    // UART TX model plus output monitor, evaluated mid-cycle
    initial begin
        RS_DONE = 1'b0;
        forever begin
            @(negedge clk);
            RS_DONE = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    RS_DONE = 1'b1;
                    last_done_cyc = cyc;
                    done_cnt++;
                end
            end
            if (RST === 1'b0) begin
                if (RS_TRG === 1'b1) begin
                    trg_cnt++;
                    if (exp_bytes.size() == 0) begin
                        check("extra_trg", exp_bytes.size(), 1);
                    end else begin
                        check("byte", RS_DATAIN, exp_bytes.pop_front());
                    end
                    check("busy_at_trg", tx_busy, 1);
                    if (byte_no > 0) check("gap", cyc - last_done_cyc, GAP + 1);
                    last_byte    = RS_DATAIN;
                    last_trg_cyc = cyc;
                    countdown    = dly[(byte_no > 3) ? 3 : byte_no];
                    byte_no++;
                end
                if (tx_done === 1'b1 || tx_err === 1'b1) begin
                    if (exp_ev.size() == 0) begin
                        check("extra_evt", exp_ev.size(), 1);
                    end else begin
                        check("event", (tx_done === 1'b1) ? 1 : 2, exp_ev.pop_front());
                    end
                    check("busy_at_end", tx_busy, 0);
                    ev_cnt++;
                    ev_cyc = cyc;
                end
            end
        end
    end

    initial begin
        int snap;
        int t0;
        int k;
        RST     = 1'b1;
        tx_trg  = 1'b0;
        cmd_tx  = 8'h00;
        addr_tx = 8'h00;
        data_tx = 8'h00;
        dly     = '{10, 10, 10, 10};
        repeat (3) @(negedge clk);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        check("rst_trg", RS_TRG, 0);
        check("rst_datain", RS_DATAIN, 8'h00);
        RST = 1'b0;

        // Basic frame
        snap = ev_cnt;
        t0   = trg_cnt;
        send_frame(8'hA5, 8'h10, 8'h3C, FLEN, 1);
        wait_evt(snap);
        check("basic_len", trg_cnt - t0, FLEN);

        // Request during WAIT of byte 1 must be ignored
        snap = ev_cnt;
        t0   = trg_cnt;
        send_frame(8'hA5, 8'h10, 8'h3C, FLEN, 1);
        k = 0;
        while (trg_cnt < t0 + 2 && k < 500) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        cmd_tx = 8'hFF;
        tx_trg = 1'b1;
        @(negedge clk);
        tx_trg = 1'b0;
        wait_evt(snap);
        repeat (40) @(negedge clk);
        check("ignored_len", trg_cnt - t0, FLEN);

        // Timeout after the addr byte
        dly  = '{10, 0, 10, 10};
        snap = ev_cnt;
        t0   = trg_cnt;
        send_frame(8'h11, 8'h22, 8'h33, 2, 2);
        wait_evt(snap);
        check("tmo_latency", ev_cyc - last_trg_cyc, TMO + 1);
        check("tmo_len", trg_cnt - t0, 2);
        @(negedge clk);
        check("tmo_busy_low", tx_busy, 0);

        // Fresh frame after timeout
        dly  = '{10, 10, 10, 10};
        snap = ev_cnt;
        t0   = trg_cnt;
        send_frame(8'h5A, 8'hC3, 8'h0F, FLEN, 1);
        wait_evt(snap);
        check("recover_len", trg_cnt - t0, FLEN);

        // RS_DONE on the timeout-match cycle
        dly  = '{10, TMO, 10, 10};
        snap = ev_cnt;
        t0   = trg_cnt;
        send_frame(8'h3E, 8'h41, 8'h99, FLEN, 1);
        wait_evt(snap);
        check("simul_len", trg_cnt - t0, FLEN);

        // Reset during GAP after the cmd byte
        dly  = '{10, 10, 10, 10};
        snap = done_cnt;
        send_frame(8'h77, 8'h88, 8'h99, FLEN, 1);
        k = 0;
        while (done_cnt == snap && k < 500) begin
            @(posedge clk);
            k++;
        end
        check("rst_mid_done_seen", done_cnt, snap + 1);
        @(negedge clk);
        exp_bytes.delete();
        exp_ev.delete();
        countdown = 0;
        RST = 1'b1;
        @(negedge clk);
        check("midrst_busy", tx_busy, 0);
        check("midrst_trg", RS_TRG, 0);
        check("midrst_datain", RS_DATAIN, 8'h00);
        check("midrst_done", tx_done, 0);
        check("midrst_err", tx_err, 0);
        RST = 1'b0;
        t0   = trg_cnt;
        snap = ev_cnt;
        repeat (60) @(negedge clk);
        check("midrst_no_trg", trg_cnt - t0, 0);
        check("midrst_no_evt", ev_cnt - snap, 0);

        // Checksum frame
        snap = ev_cnt;
        t0   = trg_cnt;
        send_frame(8'h01, 8'h02, 8'h04, FLEN, 1);
        wait_evt(snap);
        check("chk_len", trg_cnt - t0, FLEN);
        check("chk_last", last_byte, (FLEN == 4) ? 8'h07 : 8'h04);

        repeat (5) @(negedge clk);
        check("queues_empty", exp_bytes.size() + exp_ev.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
